// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile: APB3 completer with a DEPTH-entry register file.
// Addresses at or above DEPTH complete with pslverr=1; writes to them are
// dropped and reads return zero.
// Optional feature macro: APB_WAIT_EN. When defined, each transfer inserts
// WAIT_CYCLES wait states in the access phase. When undefined there is no
// wait counter and pready rises in the first access cycle.
module apb_slave_regfile #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 8,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr
);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg;
    logic              write_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic              err_reg;
    logic [DATA_W-1:0] prdata_reg;
    logic [DATA_W-1:0] reg_file [DEPTH];
    logic [DATA_W-1:0] rd_mux;
    logic              setup_hit;
    logic              addr_err;
    logic              commit;
    logic              wait_done;

    // Setup phase: selected without penable while idle. A psel+penable pair
    // seen in IDLE has no setup and is ignored.
    assign setup_hit = (state_reg == IDLE) && psel && !penable;

    // One extra bit so DEPTH == 2**ADDR_W compares correctly.
    assign addr_err = ({1'b0, paddr} >= (ADDR_W + 1)'(DEPTH));

    // A write lands only on the completing access edge of an in-range write.
    assign commit = (state_reg == ACCESS) && psel && penable && pready
                    && write_reg && !err_reg;

`ifdef APB_WAIT_EN
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    logic [CNT_W-1:0] wait_cnt_reg;

    assign wait_done = (wait_cnt_reg == CNT_W'(WAIT_CYCLES));

    // Wait counter: cleared at setup, counts access cycles until it matches
    // WAIT_CYCLES; it stops there because pready ends the transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_reg <= '0;
        end else if (setup_hit) begin
            wait_cnt_reg <= '0;
        end else if ((state_reg == ACCESS) && psel && !wait_done) begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
        end
    end
`else
    assign wait_done = 1'b1;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and handshake outputs; pready depends only on state and counter.
    always_comb begin
        state_next = state_reg;
        pready     = 1'b0;
        pslverr    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (setup_hit) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                pready  = wait_done;
                pslverr = wait_done & err_reg;
                if (!psel) begin
                    state_next = IDLE;
                end else if (penable && wait_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Capture the request during the setup phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_reg  <= '0;
            write_reg <= 1'b0;
            wdata_reg <= '0;
            err_reg   <= 1'b0;
        end else if (setup_hit) begin
            addr_reg  <= paddr;
            write_reg <= pwrite;
            wdata_reg <= pwdata;
            err_reg   <= addr_err;
        end
    end

    // Read mux over the register file, indexed by the live setup address.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (paddr == ADDR_W'(i)) begin
                rd_mux = reg_file[i];
            end
        end
    end

    // Read data is loaded at setup of a read and otherwise holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            prdata_reg <= '0;
        end else if (setup_hit && !pwrite) begin
            prdata_reg <= addr_err ? '0 : rd_mux;
        end
    end

    assign prdata = prdata_reg;

    // One storage word per index, each written only on its own commit.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
        logic [DATA_W-1:0] q_reg;

        // Register word gi.
        always_ff @(posedge clk) begin
            if (rst) begin
                q_reg <= '0;
            end else if (commit && (addr_reg == ADDR_W'(gi))) begin
                q_reg <= wdata_reg;
            end
        end

        assign reg_file[gi] = q_reg;
    end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed testbench for apb_slave_regfile (DATA_W=8, ADDR_W=8, DEPTH=8,
// WAIT_CYCLES=3). Expected wait count follows APB_WAIT_EN.
module tb_apb_slave_regfile;

`ifdef APB_WAIT_EN
    localparam int EXP_WAIT = 3;
`else
    localparam int EXP_WAIT = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       psel;
    logic       penable;
    logic       pwrite;
    logic [7:0] paddr;
    logic [7:0] pwdata;
    logic [7:0] prdata;
    logic       pready;
    logic       pslverr;

    int         ncmp  = 0;
    int         nfail = 0;
    int         cyc   = 0;
    int         last_len;
    logic [7:0] model [8];

    apb_slave_regfile #(
        .DATA_W(8), .ADDR_W(8), .DEPTH(8), .WAIT_CYCLES(3)
    ) dut (
        .clk(clk), .rst(rst), .psel(psel), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full transfer starting #1 after a rising edge; ends #1 after the
    // completing edge with psel dropped so another transfer can follow at once.
    task automatic xfer(input bit wr, input logic [7:0] idx, input logic [7:0] data,
                        input bit exp_err, input logic [7:0] exp_rd);
        int  start;
        int  waits;
        bit  done;
        start   = cyc;
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = idx;
        pwdata  = data;
        @(negedge clk);
        check("setup_pready", 32'(pready), 32'd0);
        @(posedge clk);
        #1 penable = 1'b1;
        waits = 0;
        done  = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (pready) done = 1'b1;
            else waits++;
        end
        check("pready_seen", 32'(done), 32'd1);
        check("wait_count", 32'(waits), 32'(EXP_WAIT));
        check("pslverr", 32'(pslverr), 32'(exp_err));
        if (!wr) check("prdata", 32'(prdata), 32'(exp_rd));
        @(posedge clk);
        #1;
        psel     = 1'b0;
        penable  = 1'b0;
        last_len = cyc - start;
        if (wr && !exp_err) model[idx[2:0]] = data;
        $display("xfer %s idx=%0d data=%02h err=%0b prdata=%02h waits=%0d len=%0d",
                 wr ? "WR" : "RD", idx, data, pslverr, prdata, waits, last_len);
    endtask

    initial begin
        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 8'd0; pwdata = 8'd0;
        for (int i = 0; i < 8; i++) model[i] = 8'h00;

        // Reset with psel toggling
        repeat (2) begin
            @(posedge clk);
            #1 psel = ~psel;
        end
        @(negedge clk);
        check("rst_prdata", 32'(prdata), 32'd0);
        check("rst_pready", 32'(pready), 32'd0);
        check("rst_pslverr", 32'(pslverr), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0; psel = 1'b0;
        for (int i = 0; i < 8; i++) xfer(1'b0, 8'(i), 8'h00, 1'b0, 8'h00);

        // Write/read
        xfer(1'b1, 8'd2, 8'hFF, 1'b0, 8'h00);
        xfer(1'b0, 8'd2, 8'h00, 1'b0, 8'hFF);
        xfer(1'b0, 8'd3, 8'h00, 1'b0, 8'h00);

        // Out of range
        xfer(1'b1, 8'd8, 8'hA5, 1'b1, 8'h00);
        xfer(1'b0, 8'd8, 8'h00, 1'b1, 8'h00);
        xfer(1'b0, 8'd255, 8'h00, 1'b1, 8'h00);
        for (int i = 0; i < 8; i++) xfer(1'b0, 8'(i), 8'h00, 1'b0, model[i]);

        // Wait-state path (length depends on APB_WAIT_EN)
        xfer(1'b1, 8'd5, 8'h3C, 1'b0, 8'h00);
        xfer(1'b0, 8'd5, 8'h00, 1'b0, 8'h3C);

        // Abort: drop psel in access
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'd1; pwdata = 8'h11;
        @(posedge clk);
        #1 psel = 1'b0;
        @(posedge clk);
        #1;
        xfer(1'b0, 8'd1, 8'h00, 1'b0, 8'h00);

        // Protocol violation: access phase without setup
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'd7; pwdata = 8'h99;
        repeat (2) begin
            @(negedge clk);
            check("viol_pready", 32'(pready), 32'd0);
        end
        @(posedge clk);
        #1 psel = 1'b0; penable = 1'b0;
        xfer(1'b0, 8'd7, 8'h00, 1'b0, 8'h00);

        // Back-to-back write then read of the same index
        xfer(1'b1, 8'd4, 8'h12, 1'b0, 8'h00);
        check("b2b_wr_len", 32'(last_len), 32'(2 + EXP_WAIT));
        xfer(1'b0, 8'd4, 8'h00, 1'b0, 8'h12);
        check("b2b_rd_len", 32'(last_len), 32'(2 + EXP_WAIT));

        // Reset during access: write must not commit, everything clears
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'd6; pwdata = 8'h77;
        @(posedge clk);
        #1 penable = 1'b1; rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0; psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        check("midrst_pready", 32'(pready), 32'd0);
        @(posedge clk);
        #1;
        xfer(1'b0, 8'd6, 8'h00, 1'b0, 8'h00);
        xfer(1'b0, 8'd2, 8'h00, 1'b0, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
